// File: rtl/mult_seq16_if.sv
// Multiplier request/response bundle: execute stage drives start/flush/operands,
// the multiplier returns busy, a done pulse and the held product.
interface mult_seq16_if #(
   parameter int WIDTH = 16
) ();
   logic                 start;
   logic                 flush;
   logic [WIDTH-1:0]     opA;
   logic [WIDTH-1:0]     opB;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, flush, opA, opB,
      input  busy, done, product
   );

   modport slave (
      input  start, flush, opA, opB,
      output busy, done, product
   );
endinterface

// File: rtl/mult_seq16.sv
// Radix-2 shift-add unsigned multiplier on a nibble-grouped CLA; done pulses WIDTH+1
// cycles after start is accepted. No backpressure: start is ignored while iterating.
module cla_block (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] gen;
   logic [3:0] prop;
   logic [4:0] c;

   always_comb begin
      gen  = a & b;
      prop = a ^ b;
      c[0] = cin;
      c[1] = gen[0] | (prop[0] & cin);
      c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
      c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
           | (prop[2] & prop[1] & prop[0] & cin);
      c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0])
           | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
      sum  = prop ^ c[3:0];
      cout = c[4];
   end
endmodule

module mult_seq16 #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   mult_seq16_if.slave   bus
);
   localparam int NG = WIDTH / 4;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     sum;
   logic [NG:0]          carry;
   logic [2*WIDTH-1:0]   shifted;

   assign addend   = acc_q[0] ? mcand_q : '0;
   assign carry[0] = 1'b0;

   for (genvar gi = 0; gi < NG; gi++) begin : g_cla
      cla_block u_cla (
         .a    (acc_q[WIDTH + 4*gi +: 4]),
         .b    (addend[4*gi +: 4]),
         .cin  (carry[gi]),
         .sum  (sum[4*gi +: 4]),
         .cout (carry[gi+1])
      );
   end

   // The CLA carry-out becomes the top bit after the shift; losing it breaks the high half.
   assign shifted = {carry[NG], sum, acc_q[WIDTH-1:1]};

   always_comb begin
      state_d   = state_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      product_d = product_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.start && !bus.flush) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
               mcand_d = bus.opA;
               acc_d   = {{WIDTH{1'b0}}, bus.opB};
               count_d = '0;
            end
         end
         ST_RUN: begin
            acc_d   = shifted;
            count_d = count_q + CW'(1);
            busy_d  = 1'b1;
            if (count_q == LAST) begin
               state_d   = ST_DONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               product_d = shifted;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An aborted operation must not disturb the last completed product.
      if (bus.flush) begin
         state_d   = ST_IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         product_d = product_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq16.sv
// Randomised and directed bench for mult_seq16 against a plain-arithmetic product model
// with cycle-accurate expectations for busy/done timing.
module tb_mult_seq16;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_seq16_if #(.WIDTH(W)) bus ();
   mult_seq16 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   int overlap = 0;
   logic [2*W-1:0] last_prod;

   int w_done_cnt, w_first_done, w_busy_cnt, w_busy_first, w_busy_last;
   logic [2*W-1:0] w_prod_at_done, w_prod_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (bus.busy && bus.done) overlap++;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      return (2*W)'(a) * (2*W)'(b);
   endfunction

   // Called at posedge+1; the following edge accepts the start (end of cycle 0).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.opA   = a;
      bus.opB   = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Sample n cycles numbered from cyc0 at the falling edge.
   task automatic watch(input int cyc0, input int n);
      w_done_cnt = 0; w_first_done = -1; w_busy_cnt = 0;
      w_busy_first = -1; w_busy_last = -1; w_prod_at_done = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.done) begin
            w_done_cnt++;
            if (w_first_done < 0) begin
               w_first_done   = cyc0 + i;
               w_prod_at_done = bus.product;
            end
         end
         if (bus.busy) begin
            w_busy_cnt++;
            if (w_busy_first < 0) w_busy_first = cyc0 + i;
            w_busy_last = cyc0 + i;
         end
         w_prod_last = bus.product;
         @(posedge clk); #1;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] exp;
      exp = ref_mul(a, b);
      issue(a, b);
      watch(1, 18);
      chk({tag, ":busy_span"}, {w_busy_first[15:0], w_busy_last[15:0], w_busy_cnt[15:0]},
          {16'd1, 16'd16, 16'd16});
      chk({tag, ":done_cyc"}, {w_done_cnt[15:0], w_first_done[15:0]}, {16'd1, 16'd17});
      chk({tag, ":prod"}, w_prod_at_done, exp);
      chk({tag, ":hold"}, w_prod_last, exp);
      last_prod = exp;
   endtask

   initial begin
      logic [W-1:0] a, b;
      int fc, nc;
      logic expect_done;

      rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.opA = '0; bus.opB = '0;
      last_prod = '0;
      #12;
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_prod", bus.product, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_and_check("basic_3x5", 16'd3, 16'd5);
      run_and_check("ffff_sq", 16'hFFFF, 16'hFFFF);
      chk("ffff_const", last_prod, 64'hFFFE0001);
      run_and_check("8000x2", 16'h8000, 16'h0002);
      run_and_check("zero_a", 16'h0000, 16'hABCD);
      run_and_check("zero_b", 16'hABCD, 16'h0000);

      // A second start mid-run must not recapture operands.
      issue(16'd7, 16'd9);
      watch(1, 4);
      issue(16'd1, 16'd1);
      watch(6, 20);
      chk("ignore_start:done", {w_done_cnt[15:0], w_first_done[15:0]}, {16'd1, 16'd17});
      chk("ignore_start:prod", w_prod_at_done, 32'h3F);
      last_prod = 32'h3F;

      // Back-to-back: new start held during the done cycle.
      issue(16'd2, 16'd3);
      watch(1, 16);
      chk("b2b_first_busy", w_busy_cnt, 16);
      bus.opA = 16'h0100; bus.opB = 16'h0100; bus.start = 1'b1;
      @(negedge clk);
      chk("b2b_first_done", bus.done, 1);
      chk("b2b_first_prod", bus.product, 32'h6);
      @(posedge clk); #1;
      bus.start = 1'b0;
      watch(1, 18);
      chk("b2b_second_done", {w_done_cnt[15:0], w_first_done[15:0]}, {16'd1, 16'd17});
      chk("b2b_second_busy", {w_busy_first[15:0], w_busy_cnt[15:0]}, {16'd1, 16'd16});
      chk("b2b_second_prod", w_prod_at_done, 32'h00010000);
      last_prod = 32'h00010000;

      // Flush during cycle 8.
      issue(16'h1234, 16'h5678);
      watch(1, 7);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      watch(9, 15);
      chk("flush_busy", w_busy_cnt, 0);
      chk("flush_done", w_done_cnt, 0);
      chk("flush_prod", w_prod_last, last_prod);

      // Flush beats start in the same cycle.
      bus.flush = 1'b1;
      issue(16'h00FF, 16'h00FF);
      bus.flush = 1'b0;
      watch(1, 18);
      chk("flush_vs_start", {w_busy_cnt[15:0], w_done_cnt[15:0]}, 32'd0);

      // Asynchronous reset mid-run.
      issue(16'h1111, 16'h2222);
      watch(1, 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_outputs", {bus.busy, bus.done, bus.product}, 0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      watch(0, 16);
      chk("arst_no_done", {w_busy_cnt[15:0], w_done_cnt[15:0]}, 32'd0);
      last_prod = '0;
      run_and_check("after_arst", 16'h0BAD, 16'h0CAF);

      for (int op = 0; op < 1000; op++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            a = ($urandom_range(0, 1) == 0) ? '0 : '1;
         end
         fc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 16) : 0;
         nc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         issue(a, b);
         expect_done = (fc == 0);
         w_done_cnt = 0; w_first_done = -1; w_prod_at_done = '0;
         for (int cyc = 1; cyc <= 18; cyc++) begin
            bus.flush = (cyc == fc);
            if (cyc == nc && (fc == 0 || cyc <= fc)) begin
               bus.start = 1'b1;
               bus.opA   = W'($urandom);
               bus.opB   = W'($urandom);
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
               w_done_cnt++;
               if (w_first_done < 0) begin
                  w_first_done   = cyc;
                  w_prod_at_done = bus.product;
               end
            end
            w_prod_last = bus.product;
            @(posedge clk); #1;
         end
         bus.flush = 1'b0;
         bus.start = 1'b0;
         if (expect_done) last_prod = ref_mul(a, b);
         chk("rnd_done_cnt", w_done_cnt, expect_done ? 1 : 0);
         chk("rnd_done_cyc", w_first_done, expect_done ? 17 : -1);
         chk("rnd_prod", w_prod_last, last_prod);
      end

      chk("busy_done_exclusive", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
